// File: rtl/mem_pkg.sv
// Shared memory-side types: execute-stage read request, SRAM-like bus bundle
// and the state encoding of the load-response engine.
package mem_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } read_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } dread_state_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } sram_bus_t;

  localparam logic [15:0] DBG_CNT_MAX = 16'hFFFF;

  // Bus only carries whole words; the byte offset is handled by the load unit.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/dread_resp.sv
// Load-response engine: issues one SRAM-like read per accepted load request and
// returns the data with a one-cycle strobe, discarding reads killed by a flush.
module dread_resp
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  read_req_t   mread,
  output logic [31:0] rd,
  output logic        d_data_ok,
  output logic        req,
  output logic [31:0] addr,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic [15:0] o_dbg_cnt
);

  dread_state_t r_state;
  dread_state_t w_next_state;
  logic         w_deliver;
  logic         w_start;
  logic [31:0]  r_addr;
  logic [31:0]  r_rd;
  logic         r_ok;
  logic [15:0]  r_cnt;

  assign w_start = (r_state == ST_IDLE) && mread.valid && !flush;

  // Next-state decode; w_deliver marks a read whose data reaches the pipeline.
  always_comb begin
    w_next_state = r_state;
    w_deliver    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next_state = ST_REQ;
        else         w_next_state = ST_IDLE;
      end
      ST_REQ: begin
        if (addr_ok) begin
          if (data_ok) begin
            w_next_state = ST_IDLE;
            w_deliver    = !flush;
          end else if (flush) begin
            w_next_state = ST_DROP;
          end else begin
            w_next_state = ST_WAIT;
          end
        end else if (flush) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (data_ok) begin
          w_next_state = ST_IDLE;
          w_deliver    = !flush;
        end else if (flush) begin
          w_next_state = ST_DROP;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (data_ok) w_next_state = ST_IDLE;
        else         w_next_state = ST_DROP;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= 32'd0;
      r_rd    <= 32'd0;
      r_ok    <= 1'b0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_next_state;
      r_ok    <= w_deliver;
      if (w_deliver) r_rd <= rdata;
      else           r_rd <= r_rd;
      if (w_start) r_addr <= word_align(mread.addr);
      else         r_addr <= r_addr;
      // Busy-cycle counter restarts each time the engine falls back to idle.
      if (w_next_state == ST_IDLE)                         r_cnt <= 16'd0;
      else if (r_state != ST_IDLE && r_cnt != DBG_CNT_MAX) r_cnt <= r_cnt + 16'd1;
      else                                                 r_cnt <= r_cnt;
    end
  end

  assign req       = (r_state == ST_REQ);
  assign addr      = r_addr;
  assign rd        = r_rd;
  assign d_data_ok = r_ok & ~flush;
  assign o_dbg_cnt = r_cnt;

endmodule

// File: tb/tb_dread_resp.sv
// Randomized scoreboard bench for dread_resp: stimulus pushes expected load data,
// a negedge monitor pops it on every d_data_ok and tracks the expected req/addr.
module tb_dread_resp;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush;
  read_req_t   mread;
  logic [31:0] rd;
  logic        d_data_ok, req;
  logic [31:0] addr;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [15:0] dbg_cnt;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int n_deliver = 0;
  logic [31:0] exp_q[$];
  logic        exp_req  = 1'b0;
  logic [31:0] exp_addr = 32'd0;
  logic        mon_en   = 1'b0;

  always #5 clk = ~clk;

  dread_resp dut (
    .clk(clk), .reset(reset), .flush(flush), .mread(mread),
    .rd(rd), .d_data_ok(d_data_ok), .req(req), .addr(addr),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .o_dbg_cnt(dbg_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rdata = $urandom;
  endtask

  // Monitor: pops the scoreboard on each strobe and checks the bus request.
  always @(negedge clk) begin
    if (mon_en) begin
      if (d_data_ok) begin
        pulses++;
        if (exp_q.size() == 0) chk("unexpected_pulse", 32'(d_data_ok), 32'd0);
        else                   chk("rd_data", rd, exp_q.pop_front());
      end
      chk("req", 32'(req), 32'(exp_req));
      if (req) chk("addr", addr, exp_addr);
    end
  end

  // mode: 0 normal, 1 flush in REQ before addr_ok, 2 flush first WAIT cycle,
  //       3 flush in WAIT together with data_ok, 4 flush in REQ with addr_ok
  task automatic do_read(input logic [31:0] a, input logic [31:0] data,
                         input int adly, input int ddly, input int mode);
    step();
    mread = '{valid: 1'b1, addr: a};
    exp_req = 1'b0;
    if (mode == 0) begin
      exp_q.push_back(data);
      n_deliver++;
    end
    step();
    mread.valid = 1'b0;
    mread.addr  = $urandom;
    exp_req  = 1'b1;
    exp_addr = a & 32'hFFFF_FFFC;
    if (mode == 1) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
      exp_req = 1'b0;
      chk("flushreq_pulse", 32'(d_data_ok), 32'd0);
      step();
      chk("flushreq_cnt", 32'(dbg_cnt), 32'd0);
      return;
    end
    for (int i = 0; i < adly; i++) step();
    addr_ok = 1'b1;
    flush   = (mode == 4);
    if (ddly == 0) begin
      data_ok = 1'b1;
      rdata   = data;
      chk("dbg_cnt", 32'(dbg_cnt), 32'(adly));
    end
    step();
    addr_ok = 1'b0;
    data_ok = 1'b0;
    flush   = 1'b0;
    exp_req = 1'b0;
    for (int j = 1; j <= ddly; j++) begin
      flush = (mode == 2 && j == 1) || (mode == 3 && j == ddly);
      if (j == ddly) begin
        data_ok = 1'b1;
        rdata   = data;
        chk("dbg_cnt", 32'(dbg_cnt), 32'(adly + ddly));
      end
      step();
      data_ok = 1'b0;
      flush   = 1'b0;
    end
    chk("pulse_time", 32'(d_data_ok), 32'(mode == 0));
    if (mode == 0) chk("rd_now", rd, data);
    step();
    chk("pulse_len", 32'(d_data_ok), 32'd0);
    chk("idle_cnt", 32'(dbg_cnt), 32'd0);
  endtask

  initial begin
    logic [31:0] vals [3];
    logic [31:0] base;
    logic [31:0] keep_rd;
    int          p0;
    int          m, ad, dd;

    reset = 1'b1;
    flush = 1'b1;
    mread = '{valid: 1'b1, addr: 32'hFFFF_FFFF};
    addr_ok = 1'b1;
    data_ok = 1'b1;
    rdata   = 32'hA5A5_A5A5;
    repeat (3) step();
    chk("rst_rd", rd, 32'd0);
    chk("rst_ok", 32'(d_data_ok), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_cnt", 32'(dbg_cnt), 32'd0);
    reset = 1'b0;
    flush = 1'b0;
    mread = '{valid: 1'b0, addr: 32'd0};
    addr_ok = 1'b0;
    data_ok = 1'b0;
    mon_en  = 1'b1;
    step();

    do_read(32'h8000_1004, 32'hDEAD_BEEF, 0, 0, 0);
    do_read(32'h4000_0012, 32'h1234_5678, 3, 2, 0);
    do_read(32'h0000_2222, 32'h0BAD_F00D, 1, 2, 2);
    do_read(32'h0000_3000, 32'h3333_4444, 0, 1, 0);
    do_read(32'h0000_4001, 32'h5555_6666, 2, 0, 1);
    do_read(32'h0000_5003, 32'h7777_8888, 0, 2, 3);
    do_read(32'h0000_6000, 32'h9999_AAAA, 1, 1, 4);
    do_read(32'h0000_7004, 32'hBBBB_CCCC, 0, 0, 0);

    // Flush in IDLE blocks a new request; flush on the strobe cycle hides it.
    step();
    mread = '{valid: 1'b1, addr: 32'h0000_8000};
    flush = 1'b1;
    step();
    mread.valid = 1'b0;
    flush = 1'b0;
    step();
    keep_rd = rd;
    mread = '{valid: 1'b1, addr: 32'h0000_9000};
    step();
    mread.valid = 1'b0;
    exp_req  = 1'b1;
    exp_addr = 32'h0000_9000;
    addr_ok = 1'b1;
    data_ok = 1'b1;
    rdata   = 32'h1111_2222;
    step();
    addr_ok = 1'b0;
    data_ok = 1'b0;
    exp_req = 1'b0;
    flush   = 1'b1;
    #1;
    chk("flush_masks_ok", 32'(d_data_ok), 32'd0);
    step();
    flush = 1'b0;
    chk("flush_masks_next", 32'(d_data_ok), 32'd0);
    chk("rd_changed", 32'(rd != keep_rd), 32'd1);

    // Reset while waiting for data, then a stray data_ok.
    step();
    mread = '{valid: 1'b1, addr: 32'h0000_A008};
    step();
    mread.valid = 1'b0;
    exp_req  = 1'b1;
    exp_addr = 32'h0000_A008;
    addr_ok  = 1'b1;
    step();
    addr_ok = 1'b0;
    exp_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset   = 1'b0;
    data_ok = 1'b1;
    rdata   = 32'hCAFE_CAFE;
    step();
    data_ok = 1'b0;
    chk("rst_mid_rd", rd, 32'd0);
    chk("rst_mid_ok", 32'(d_data_ok), 32'd0);
    chk("rst_mid_req", 32'(req), 32'd0);
    chk("rst_mid_cnt", 32'(dbg_cnt), 32'd0);
    step();
    chk("rst_mid_ok2", 32'(d_data_ok), 32'd0);
    do_read(32'h0000_B00C, 32'h600D_DA7A, 0, 0, 0);

    // Back-to-back with valid held: a read every two cycles, never overlapping.
    base = 32'h0001_0000;
    p0   = pulses;
    for (int k = 0; k < 3; k++) begin
      vals[k] = $urandom;
      exp_q.push_back(vals[k]);
      n_deliver++;
    end
    step();
    for (int i = 0; i < 6; i++) begin
      mread.valid = (i < 5);
      mread.addr  = base + 32'(i * 4);
      exp_req  = (i % 2 == 1);
      exp_addr = base + 32'((i - 1) * 4);
      addr_ok  = exp_req;
      data_ok  = exp_req;
      if (exp_req) rdata = vals[i / 2];
      step();
    end
    addr_ok = 1'b0;
    data_ok = 1'b0;
    exp_req = 1'b0;
    repeat (2) step();
    chk("b2b_pulses", 32'(pulses - p0), 32'd3);

    for (int n = 0; n < 30; n++) begin
      m  = $urandom_range(0, 4);
      ad = $urandom_range(0, 3);
      dd = $urandom_range(0, 3);
      if (m == 2 && dd < 2) dd = 2;
      if ((m == 3 || m == 4) && dd < 1) dd = 1;
      do_read($urandom, $urandom, ad, dd, m);
    end

    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("pulse_count", 32'(pulses), 32'(n_deliver));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
